// File: rtl/wm_pkg.sv
// wm_pkg: shared program encodings, phase-index tables, FSM state type and abort length
package wm_pkg;
  localparam logic [1:0] PROG_NORMAL   = 2'b00;
  localparam logic [1:0] PROG_QUICK    = 2'b01;
  localparam logic [1:0] PROG_HEAVY    = 2'b10;
  localparam logic [1:0] PROG_DELICATE = 2'b11;
  // Tables are packed {delicate, heavy, quick, normal}, indexed by program code
  localparam logic [7:0] WASH_TBL  = {2'd1, 2'd3, 2'd1, 2'd2};
  localparam logic [7:0] RINSE_TBL = {2'd1, 2'd2, 2'd0, 2'd1};
  localparam logic [7:0] DRY_TBL   = {2'd0, 2'd3, 2'd1, 2'd2};
  localparam int ABORT_LEN = 4;
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, COMPLETE, ABORT} state_t;
  function automatic logic [1:0] tbl_idx(input logic [7:0] tbl, input logic [1:0] prog);
    return tbl[{prog, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/wm_debounce.sv
// wm_debounce: 2-flop synchroniser followed by a stable-sample debounce counter
// Ports: clk, rst_n (async, active-low), btn (raw async button), db (debounced level)
module wm_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  // cnt tracks how many consecutive samples disagree with db; any agreeing sample restarts it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt  <= '0;
      db   <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      if (sync[1] == db)
        cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt <= '0;
        db  <= sync[1];
      end else
        cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/wm_panel_ctrl.sv
// wm_panel_ctrl: washing-machine front-panel controller sequencing a downstream cycle controller
// Ports: clk, rst_n (async, active-low); btn_start, btn_cancel, door_closed (raw async inputs);
//   prog_sel (program switch); wash/rinse/dry_enable, timer_done (from cycle controller);
//   start, phase_sel, ctrl_rst_n (to cycle controller); busy, cycle_done, door_alarm,
//   cycles_completed (status). All outputs registered.
// Build option: define WM_CYCLE_COUNT_EN to build the saturating completed-cycle counter;
//   otherwise cycles_completed is tied to 0.
module wm_panel_ctrl
  import wm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_start,
  input  logic        btn_cancel,
  input  logic        door_closed,
  input  logic [1:0]  prog_sel,
  input  logic        wash_enable,
  input  logic        rinse_enable,
  input  logic        dry_enable,
  input  logic        timer_done,
  output logic        start,
  output logic [1:0]  phase_sel,
  output logic        ctrl_rst_n,
  output logic        busy,
  output logic        cycle_done,
  output logic        door_alarm,
  output logic [15:0] cycles_completed
);
  localparam int AW = $clog2(ABORT_LEN);
  state_t        state, state_n;
  logic [1:0]    door_sync, prog_q, phase_n;
  logic [AW-1:0] abort_cnt;
  logic          start_db, cancel_db, start_db_q, cancel_db_q, start_ev, cancel_ev, rst_rel;
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn(btn_start), .db(start_db));
  wm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .clk(clk), .rst_n(rst_n), .btn(btn_cancel), .db(cancel_db));
  assign start_ev  = start_db & ~start_db_q;
  assign cancel_ev = cancel_db & ~cancel_db_q;
  always_comb begin
    state_n = state;
    phase_n = phase_sel;
    case (state)
      IDLE:
        if (start_ev && !cancel_ev && door_sync[1]) begin
          state_n = LAUNCH;
          phase_n = tbl_idx(WASH_TBL, prog_sel);
        end
      LAUNCH:   state_n = cancel_ev ? ABORT : RUN;
      RUN:
        if (cancel_ev)
          state_n = ABORT;
        else if (timer_done) begin
          state_n = dry_enable ? COMPLETE : RUN;
          phase_n = dry_enable   ? phase_sel :
                    rinse_enable ? tbl_idx(DRY_TBL, prog_q) :
                    wash_enable  ? tbl_idx(RINSE_TBL, prog_q) : phase_sel;
        end
      COMPLETE: state_n = (start_ev || cancel_ev) ? IDLE : COMPLETE;
      ABORT:    state_n = (abort_cnt == AW'(ABORT_LEN - 1)) ? IDLE : ABORT;
      default:  state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      prog_q      <= PROG_NORMAL;
      abort_cnt   <= '0;
      door_sync   <= '0;
      start_db_q  <= 1'b0;
      cancel_db_q <= 1'b0;
      rst_rel     <= 1'b0;
    end else begin
      state       <= state_n;
      door_sync   <= {door_sync[0], door_closed};
      start_db_q  <= start_db;
      cancel_db_q <= cancel_db;
      rst_rel     <= 1'b1;
      abort_cnt   <= (state == ABORT) ? abort_cnt + 1'b1 : '0;
      if (state == IDLE && state_n == LAUNCH)
        prog_q <= prog_sel;
    end
  // Outputs are registered from the next state so they line up with the state they describe;
  // rst_rel delays ctrl_rst_n release to the second edge after reset removal.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      start      <= 1'b0;
      phase_sel  <= 2'b00;
      ctrl_rst_n <= 1'b0;
      busy       <= 1'b0;
      cycle_done <= 1'b0;
      door_alarm <= 1'b0;
    end else begin
      start      <= state_n == LAUNCH;
      phase_sel  <= phase_n;
      ctrl_rst_n <= rst_rel && state_n != ABORT;
      busy       <= state_n inside {LAUNCH, RUN, ABORT};
      cycle_done <= state_n == COMPLETE;
      door_alarm <= (state_n inside {LAUNCH, RUN, ABORT}) && !door_sync[1];
    end
`ifdef WM_CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      cnt_q <= '0;
    else if (state == RUN && state_n == COMPLETE && cnt_q != 16'hFFFF)
      cnt_q <= cnt_q + 1'b1;
  assign cycles_completed = cnt_q;
`else
  assign cycles_completed = '0;
`endif
endmodule
